// File: rtl/pillar_pkg.sv
// Shared definitions for the Pillar core: opcodes, instruction-type codes,
// load funct3 encodings and the writeback state encoding.
package pillar_pkg;

   localparam logic [6:0] DECODE_R_TYPE = 7'b0110011;
   localparam logic [6:0] DECODE_I_TYPE = 7'b0010011;
   localparam logic [6:0] DECODE_S_TYPE = 7'b0100011;
   localparam logic [6:0] DECODE_L_TYPE = 7'b0000011;
   localparam logic [6:0] DECODE_U_TYPE = 7'b0110111;

   typedef enum logic [2:0] {
      RTYPE = 3'd0,
      ITYPE = 3'd1,
      STYPE = 3'd2,
      LTYPE = 3'd3,
      UTYPE = 3'd4
   } itype_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // state      | meaning
   // WB_IDLE    | ready for a new result
   // WB_WAIT_MEM| load accepted, waiting for memory read data
   typedef enum logic [0:0] {
      WB_IDLE     = 1'b0,
      WB_WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension. The misaligned flag depends only on
// funct3 and addr_lo so it can be used at acceptance time.
module load_align
   import pillar_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o,
   output logic        misaligned_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   // Lane select, then extend according to the load width; unknown codes act as LW.
   always_comb begin
      byte_w       = rdata_i[7:0];
      half_w       = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      data_o       = rdata_i;
      misaligned_o = (addr_lo_i != 2'd0);
      case (addr_lo_i)
         2'd0:    byte_w = rdata_i[7:0];
         2'd1:    byte_w = rdata_i[15:8];
         2'd2:    byte_w = rdata_i[23:16];
         default: byte_w = rdata_i[31:24];
      endcase
      case (funct3_i)
         F3_LB: begin
            data_o       = {{24{byte_w[7]}}, byte_w};
            misaligned_o = 1'b0;
         end
         F3_LBU: begin
            data_o       = {24'd0, byte_w};
            misaligned_o = 1'b0;
         end
         F3_LH: begin
            data_o       = {{16{half_w[15]}}, half_w};
            misaligned_o = addr_lo_i[0];
         end
         F3_LHU: begin
            data_o       = {16'd0, half_w};
            misaligned_o = addr_lo_i[0];
         end
         default: begin
            data_o       = rdata_i;
            misaligned_o = (addr_lo_i != 2'd0);
         end
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU/U-type results directly, waits for load data
// (with a timeout), drives the register-file write port and keeps a
// per-register pending scoreboard for hazard stalls.
module writeback_unit
   import pillar_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        res_valid_i,
   output logic        res_ready_o,
   input  logic        res_is_load_i,
   input  logic [31:0] res_data_i,
   input  logic [4:0]  res_rd_i,
   input  logic [2:0]  res_funct3_i,
   input  logic [1:0]  res_addr_lo_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] wd_o,
   output logic [4:0]  wd_rd_o,
   output logic        wd_q_o,
   output logic [31:0] pend_o,
   output logic        err_o
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   wb_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    rd_q, rd_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    lo_q, lo_d;
   logic [31:0]   wd_data_q, wd_data_d;
   logic [4:0]    wd_rd_q, wd_rd_d;
   logic          wd_vld_q, wd_vld_d;
   logic          err_q, err_d;
   logic [4:0]    err_rd_q, err_rd_d;
   logic [31:0]   pend_q, pend_d;
   logic [31:0]   set_mask, clr_mask;

   logic [2:0]    align_f3;
   logic [1:0]    align_lo;
   logic [31:0]   align_data;
   logic          align_mis;

   // In IDLE the aligner judges the offered load; in WAIT_MEM it extends the returning word.
   always_comb begin
      align_f3 = (state_q == WB_IDLE) ? res_funct3_i  : f3_q;
      align_lo = (state_q == WB_IDLE) ? res_addr_lo_i : lo_q;
   end

   load_align u_load_align (
      .funct3_i     (align_f3),
      .addr_lo_i    (align_lo),
      .rdata_i      (mem_rdata_i),
      .data_o       (align_data),
      .misaligned_o (align_mis)
   );

   // Next-state, write-port and scoreboard logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      f3_d      = f3_q;
      lo_d      = lo_q;
      wd_data_d = wd_data_q;
      wd_rd_d   = wd_rd_q;
      wd_vld_d  = 1'b0;
      err_d     = 1'b0;
      err_rd_d  = err_rd_q;
      set_mask  = '0;
      clr_mask  = '0;

      // A bit stays set through its strobe/error cycle and drops afterwards.
      if (wd_vld_q) clr_mask[wd_rd_q] = 1'b1;
      if (err_q)    clr_mask[err_rd_q] = 1'b1;

      case (state_q)
         WB_IDLE: begin
            if (res_valid_i) begin
               if (!res_is_load_i) begin
                  if (res_rd_i != 5'd0) begin
                     wd_data_d = res_data_i;
                     wd_rd_d   = res_rd_i;
                     wd_vld_d  = 1'b1;
                  end
                  set_mask[res_rd_i] = 1'b1;
               end else if (align_mis) begin
                  // Nothing was marked pending, so point the clear at x0.
                  err_d    = 1'b1;
                  err_rd_d = 5'd0;
               end else begin
                  rd_d               = res_rd_i;
                  f3_d               = res_funct3_i;
                  lo_d               = res_addr_lo_i;
                  cnt_d              = '0;
                  state_d            = WB_WAIT_MEM;
                  set_mask[res_rd_i] = 1'b1;
               end
            end
         end
         WB_WAIT_MEM: begin
            if (mem_rvalid_i) begin
               if (rd_q != 5'd0) begin
                  wd_data_d = align_data;
                  wd_rd_d   = rd_q;
                  wd_vld_d  = 1'b1;
               end else begin
                  // Nothing was set for x0; keep the clear harmless.
                  wd_vld_d  = 1'b0;
               end
               state_d = WB_IDLE;
            end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
               err_d    = 1'b1;
               err_rd_d = rd_q;
               state_d  = WB_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = WB_IDLE;
      endcase

      // New acceptance wins over a clear of the same bit; x0 never pends.
      pend_d = ((pend_q & ~clr_mask) | set_mask) & ~32'd1;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WB_IDLE;
         cnt_q     <= '0;
         rd_q      <= '0;
         f3_q      <= '0;
         lo_q      <= '0;
         wd_data_q <= '0;
         wd_rd_q   <= '0;
         wd_vld_q  <= 1'b0;
         err_q     <= 1'b0;
         err_rd_q  <= '0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         f3_q      <= f3_d;
         lo_q      <= lo_d;
         wd_data_q <= wd_data_d;
         wd_rd_q   <= wd_rd_d;
         wd_vld_q  <= wd_vld_d;
         err_q     <= err_d;
         err_rd_q  <= err_rd_d;
         pend_q    <= pend_d;
      end
   end

   assign res_ready_o = (state_q == WB_IDLE);
   assign wd_o        = wd_data_q;
   assign wd_rd_o     = wd_rd_q;
   assign wd_q_o      = wd_vld_q;
   assign pend_o      = pend_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model.
module tb_writeback_unit;
   import pillar_pkg::*;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        res_valid_i = 1'b0;
   logic        res_ready_o;
   logic        res_is_load_i = 1'b0;
   logic [31:0] res_data_i = '0;
   logic [4:0]  res_rd_i = '0;
   logic [2:0]  res_funct3_i = '0;
   logic [1:0]  res_addr_lo_i = '0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic [31:0] wd_o;
   logic [4:0]  wd_rd_o;
   logic        wd_q_o;
   logic [31:0] pend_o;
   logic        err_o;

   always #5 clk = ~clk;

   writeback_unit #(.MEM_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .reset         (reset),
      .res_valid_i   (res_valid_i),
      .res_ready_o   (res_ready_o),
      .res_is_load_i (res_is_load_i),
      .res_data_i    (res_data_i),
      .res_rd_i      (res_rd_i),
      .res_funct3_i  (res_funct3_i),
      .res_addr_lo_i (res_addr_lo_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .wd_o          (wd_o),
      .wd_rd_o       (wd_rd_o),
      .wd_q_o        (wd_q_o),
      .pend_o        (pend_o),
      .err_o         (err_o)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding load tracked as a transaction.
   bit          m_busy = 0;
   int          m_start = 0;
   logic [4:0]  m_rd = '0;
   logic [2:0]  m_f3 = '0;
   logic [1:0]  m_lo = '0;
   int          cyc = 0;
   logic [31:0] e_wd = '0;
   logic [4:0]  e_rd = '0;
   bit          e_wq = 0;
   bit          e_err = 0;
   logic [31:0] e_pend = '0;

   function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * int'(lo))) & 32'hFF;
      h = (w >> (lo[1] ? 16 : 0)) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic bit ref_mis(input logic [2:0] f3, input logic [1:0] lo);
      if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
      if (f3 == 3'b001 || f3 == 3'b101) return (int'(lo) % 2) != 0;
      return lo != 2'd0;
   endfunction

   task automatic model_edge(input bit rst, input bit v, input bit ld, input logic [31:0] d,
                             input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                             input bit rv, input logic [31:0] rdat);
      logic [31:0] p;
      p     = '0;
      e_wq  = 0;
      e_err = 0;
      cyc++;
      if (rst) begin
         m_busy = 0;
         e_wd   = '0;
         e_rd   = '0;
         e_pend = '0;
         return;
      end
      if (!m_busy) begin
         if (v) begin
            if (!ld) begin
               if (rd != 0) begin
                  e_wq = 1; e_wd = d; e_rd = rd; p[rd] = 1'b1;
               end
            end else if (ref_mis(f3, lo)) begin
               e_err = 1;
            end else begin
               m_busy = 1; m_rd = rd; m_f3 = f3; m_lo = lo; m_start = cyc;
            end
         end
      end else if (rv) begin
         m_busy = 0;
         if (m_rd != 0) begin
            e_wq = 1; e_wd = ref_align(m_f3, m_lo, rdat); e_rd = m_rd;
         end
         p[m_rd] = 1'b1;
      end else if (cyc - m_start == TMO + 1) begin
         m_busy  = 0;
         e_err   = 1;
         p[m_rd] = 1'b1;
      end
      if (m_busy) p[m_rd] = 1'b1;
      p[0]   = 1'b0;
      e_pend = p;
   endtask

   task automatic step(input bit rst, input bit v, input bit ld, input logic [31:0] d,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                       input bit rv, input logic [31:0] rdat);
      @(negedge clk);
      reset         = rst;
      res_valid_i   = v;
      res_is_load_i = ld;
      res_data_i    = d;
      res_rd_i      = rd;
      res_funct3_i  = f3;
      res_addr_lo_i = lo;
      mem_rvalid_i  = rv;
      mem_rdata_i   = rdat;
      chk("ready", res_ready_o, m_busy ? 32'd0 : 32'd1);
      @(posedge clk);
      model_edge(rst, v, ld, d, rd, f3, lo, rv, rdat);
      #1;
      chk("wd_q", wd_q_o, e_wq);
      chk("err", err_o, e_err);
      chk("pend", pend_o, e_pend);
      chk("wd", wd_o, e_wd);
      chk("wd_rd", wd_rd_o, e_rd);
   endtask

   task automatic idle(input bit rv = 0, input logic [31:0] rdat = '0);
      step(0, 0, 0, 32'h0, 5'd0, 3'd0, 2'd0, rv, rdat);
   endtask

   task automatic alu(input logic [4:0] rd, input logic [31:0] d);
      step(0, 1, 0, d, rd, 3'd0, 2'd0, 0, 32'h0);
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
      step(0, 1, 1, 32'h0, rd, f3, lo, 0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // ALU back-to-back
      alu(5'd5, 32'h1234);
      chk("b2b_pend5", pend_o, 32'h0000_0020);
      alu(5'd6, 32'hCAFE);
      chk("b2b_wd6", wd_o, 32'hCAFE);
      chk("b2b_pend6", pend_o, 32'h0000_0040);
      idle();
      chk("b2b_pend_clr", pend_o, 32'h0);

      // LB sign extension, data three cycles after acceptance
      load(5'd7, F3_LB, 2'd2);
      idle();
      idle();
      idle(1, 32'h0080_0000);
      chk("lb_wd", wd_o, 32'hFFFF_FF80);
      chk("lb_rd", wd_rd_o, 32'd7);

      // LHU / LBU zero extension
      load(5'd8, F3_LHU, 2'd2);
      idle(1, 32'hBEEF_0000);
      chk("lhu_wd", wd_o, 32'h0000_BEEF);
      load(5'd8, F3_LBU, 2'd3);
      idle(1, 32'h8000_0000);
      chk("lbu_wd", wd_o, 32'h0000_0080);

      // Misaligned LW, then an immediate ALU result
      load(5'd4, F3_LW, 2'd1);
      chk("mis_err", err_o, 32'd1);
      chk("mis_pend", pend_o, 32'h0);
      alu(5'd3, 32'h0000_0033);
      chk("mis_next", wd_q_o, 32'd1);

      // Timeout: err exactly 17 cycles after acceptance
      load(5'd9, F3_LW, 2'd0);
      for (int i = 0; i < TMO; i++) idle();
      chk("tmo_early", err_o, 32'd0);
      idle();
      chk("tmo_err", err_o, 32'd1);
      chk("tmo_nowr", wd_q_o, 32'd0);
      idle();
      chk("tmo_pend", pend_o, 32'h0);

      // x0 write suppressed
      alu(5'd0, 32'hDEAD_BEEF);
      chk("x0_stb", wd_q_o, 32'd0);

      // Reset during WAIT_MEM, then a late data pulse
      load(5'd10, F3_LW, 2'd0);
      idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1, 32'h1111_2222);
      chk("rst_wd", wd_o, 32'h0);
      chk("rst_stb", wd_q_o, 32'd0);
      chk("rst_ready", res_ready_o, 32'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit          r_rst, r_v, r_ld, r_rv;
         logic [4:0]  r_rd;
         logic [2:0]  r_f3;
         logic [1:0]  r_lo;
         r_rst = ($urandom_range(0, 499) == 0);
         r_v   = ($urandom_range(0, 1) == 1);
         r_ld  = ($urandom_range(0, 2) == 0);
         r_rv  = ($urandom_range(0, 4) == 0);
         r_rd  = 5'($urandom_range(0, 31));
         r_f3  = 3'($urandom_range(0, 7));
         r_lo  = 2'($urandom_range(0, 3));
         step(r_rst, r_v, r_ld, $urandom, r_rd, r_f3, r_lo, r_rv, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
